// File: rtl/mem_access_unit.sv
// Memory-stage access unit for an RV32I pipeline.
// Turns a load/store in the MEM stage into a single registered request on the
// data-memory bus, waits for the acknowledge (or gives up after a bounded
// number of cycles), and returns sign/zero-extended load data.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wrap_load_out,
  output logic        load_valid,
  output logic        stall,
  output logic        access_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // RV32I funct3 access-size codes.
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  // Timeout limit in counter width; the legal range 1..255 fits in 8 bits.
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state;
  logic [7:0]  busy_cnt;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;

  logic        legal;
  logic        aligned;
  logic        one_op;
  logic        req_seen;
  logic        start;
  logic        reject;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  // Select the load lane by latched byte offset and extend it per funct3.
  function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      F_B:     r = {{24{b[7]}}, b};
      F_BU:    r = {24'h0, b};
      F_H:     r = {{16{h[15]}}, h};
      F_HU:    r = {16'h0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Classify the presented access: legal funct3 for its direction, and alignment.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    legal   = 1'b0;
    aligned = 1'b1;
    case (funct3_in)
      F_B:  legal = 1'b1;
      F_H: begin
        legal   = 1'b1;
        aligned = ~addr_in[0];
      end
      F_W: begin
        legal   = 1'b1;
        aligned = (addr_in[1:0] == 2'b00);
      end
      F_BU: legal = mem_read_in;
      F_HU: begin
        legal   = mem_read_in;
        aligned = ~addr_in[0];
      end
      default: legal = 1'b0;
    endcase
  end

  // Replicate store data across lanes and form the byte-enable mask.
  always_comb begin
    st_wdata = store_data_in;
    st_wstrb = 4'b1111;
    case (funct3_in[1:0])
      2'b00: begin
        st_wdata = {4{store_data_in[7:0]}};
        st_wstrb = 4'b0001 << addr_in[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data_in[15:0]}};
        st_wstrb = 4'b0011 << {addr_in[1], 1'b0};
      end
      default: begin
        st_wdata = store_data_in;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  assign one_op   = mem_read_in ^ mem_write_in;
  assign req_seen = (state == IDLE) && valid_in && (mem_read_in || mem_write_in);
  assign start    = req_seen && one_op && legal && aligned;
  assign reject   = req_seen && !(one_op && legal && aligned);

  // The pipeline is held while an access is launching or outstanding; never in reset.
  assign stall = rst && (start || (state == BUSY));

  // Access FSM with registered bus outputs, load result and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      busy_cnt      <= 8'd0;
      lat_funct3    <= 3'b000;
      lat_off       <= 2'b00;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'h0;
      dmem_wdata    <= 32'h0;
      dmem_wstrb    <= 4'b0000;
      wrap_load_out <= 32'h0;
      load_valid    <= 1'b0;
      access_err    <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      load_valid <= 1'b0;
      access_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= BUSY;
            busy_cnt   <= 8'd1;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_in;
            dmem_addr  <= {addr_in[31:2], 2'b00};
            dmem_wdata <= mem_write_in ? st_wdata : 32'h0;
            dmem_wstrb <= mem_write_in ? st_wstrb : 4'b0000;
            lat_funct3 <= funct3_in;
            lat_off    <= addr_in[1:0];
          end else if (reject) begin
            access_err <= 1'b1;
          end
        end
        BUSY: begin
          // An acknowledge in the final allowed cycle still completes normally.
          if (dmem_ack) begin
            state    <= DONE;
            busy_cnt <= 8'd0;
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              wrap_load_out <= extend_load(lat_funct3, lat_off, dmem_rdata);
              load_valid    <= 1'b1;
            end
          end else if (busy_cnt == TIMEOUT_LIM) begin
            state      <= DONE;
            busy_cnt   <= 8'd0;
            dmem_req   <= 1'b0;
            access_err <= 1'b1;
            if (!dmem_we) begin
              wrap_load_out <= 32'h0;
            end
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        DONE: begin
          // The instruction presented here is the one just served; let it leave.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of single accesses with
// hand-computed bus and load results, plus sequences for timeout, reset
// during an outstanding access, and no-op requests.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] wrap_load_out;
  logic        load_valid;
  logic        stall;
  logic        access_err;

  int checks;
  int failures;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .funct3_in     (funct3_in),
    .addr_in       (addr_in),
    .store_data_in (store_data_in),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_wstrb    (dmem_wstrb),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wrap_load_out (wrap_load_out),
    .load_valid    (load_valid),
    .stall         (stall),
    .access_err    (access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    int          ack_k;    // BUSY cycle (1-based) in which ack is driven
    logic [31:0] rdata;
    logic        err;      // access expected to be rejected
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_load;   // wrap_load_out expected after the access
    logic        e_lv;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in      = 1'b0;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    funct3_in     = 3'b000;
    addr_in       = 32'h0;
    store_data_in = 32'h0;
    dmem_ack      = 1'b0;
  endtask

  // Present one access, follow it through BUSY/DONE and compare every cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int stall_cnt;
    string tag;
    stall_cnt = 0;
    tag = $sformatf("v%0d", idx);
    valid_in      = 1'b1;
    mem_read_in   = v.rd;
    mem_write_in  = v.wr;
    funct3_in     = v.f3;
    addr_in       = v.addr;
    store_data_in = v.sdata;
    dmem_ack      = 1'b0;
    dmem_rdata    = 32'h5A5A_5A5A;
    @(negedge clk);
    check_bit({tag, "_start_stall"}, stall, !v.err);
    if (stall) stall_cnt++;
    next_cycle();
    if (v.err) begin
      idle_inputs();
      @(negedge clk);
      check_bit({tag, "_err_pulse"}, access_err, 1'b1);
      check_bit({tag, "_err_noreq"}, dmem_req, 1'b0);
      check_bit({tag, "_err_stall"}, stall, 1'b0);
      check({tag, "_err_load_held"}, wrap_load_out, v.e_load);
      next_cycle();
      @(negedge clk);
      check_bit({tag, "_err_cleared"}, access_err, 1'b0);
      check_bit({tag, "_err_noreq2"}, dmem_req, 1'b0);
      next_cycle();
      return;
    end
    for (int k = 1; k <= v.ack_k; k++) begin
      if (k == v.ack_k) begin
        dmem_ack   = 1'b1;
        dmem_rdata = v.rdata;
      end
      @(negedge clk);
      check_bit({tag, "_busy_req"}, dmem_req, 1'b1);
      check({tag, "_busy_addr"}, dmem_addr, v.e_addr);
      check_bit({tag, "_busy_we"}, dmem_we, v.e_we);
      check({tag, "_busy_wstrb"}, {28'h0, dmem_wstrb}, {28'h0, v.e_wstrb});
      if (v.wr) check({tag, "_busy_wdata"}, dmem_wdata, v.e_wdata);
      check_bit({tag, "_busy_stall"}, stall, 1'b1);
      if (stall) stall_cnt++;
      next_cycle();
    end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h5A5A_5A5A;
    // DONE: same instruction still presented, must not relaunch.
    @(negedge clk);
    check_bit({tag, "_done_req"}, dmem_req, 1'b0);
    check_bit({tag, "_done_stall"}, stall, 1'b0);
    check_bit({tag, "_done_lv"}, load_valid, v.e_lv);
    check_bit({tag, "_done_err"}, access_err, 1'b0);
    check({tag, "_done_load"}, wrap_load_out, v.e_load);
    check({tag, "_stall_cycles"}, stall_cnt, 1 + v.ack_k);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_bit({tag, "_idle_req"}, dmem_req, 1'b0);
    check_bit({tag, "_idle_lv"}, load_valid, 1'b0);
    check_bit({tag, "_idle_stall"}, stall, 1'b0);
    check({tag, "_idle_load"}, wrap_load_out, v.e_load);
    next_cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //         rd    wr    f3      addr          sdata         ack rdata         err   e_addr        we    e_wdata       strb     e_load        lv
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        2, 32'h80FF_1234, 1'b0, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'hFFFF_FF80, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        1, 32'h80FF_1234, 1'b0, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'h0000_80FF, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        1, 32'h80FF_1234, 1'b0, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'hFFFF_80FF, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 1, 32'h0,        1'b0, 32'h0000_0200, 1'b1, 32'hABAB_ABAB, 4'b0010, 32'hFFFF_80FF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        4'b0000, 32'hFFFF_80FF, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        4'b0000, 32'hFFFF_80FF, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h1234_5678, 3, 32'h0,        1'b0, 32'h0000_0300, 1'b1, 32'h5678_5678, 4'b1100, 32'hFFFF_80FF, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'hDEAD_BEEF, 1, 32'h0,        1'b0, 32'h0000_0404, 1'b1, 32'hDEAD_BEEF, 4'b1111, 32'hFFFF_80FF, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        1, 32'h0000_A500, 1'b0, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'hFFFF_FFA5, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0100, 32'h0,        2, 32'h0000_A5F0, 1'b0, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'h0000_00F0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h0000_0408, 32'h0,        4, 32'h1234_5678, 1'b0, 32'h0000_0408, 1'b0, 32'h0,        4'b0000, 32'h1234_5678, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h0000_0301, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h1234_5678, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h0000_0200, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h1234_5678, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h1234_5678, 1'b0};

    idle_inputs();
    dmem_rdata = 32'h0;
    rst = 1'b0;
    #1;
    // Reset state, with a request visible on the inputs.
    valid_in    = 1'b1;
    mem_read_in = 1'b1;
    #1;
    check_bit("rst_stall", stall, 1'b0);
    check_bit("rst_req", dmem_req, 1'b0);
    check({"rst_addr"}, dmem_addr, 32'h0);
    check_bit("rst_lv", load_valid, 1'b0);
    check_bit("rst_err", access_err, 1'b0);
    check("rst_load", wrap_load_out, 32'h0);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Timeout: load with no ack, limit of 4 BUSY cycles.
    valid_in    = 1'b1;
    mem_read_in = 1'b1;
    funct3_in   = 3'b010;
    addr_in     = 32'h0000_0100;
    next_cycle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_bit($sformatf("to_busy%0d_req", k), dmem_req, 1'b1);
      check_bit($sformatf("to_busy%0d_stall", k), stall, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    check_bit("to_done_req", dmem_req, 1'b0);
    check_bit("to_done_err", access_err, 1'b1);
    check_bit("to_done_lv", load_valid, 1'b0);
    check_bit("to_done_stall", stall, 1'b0);
    check("to_done_load", wrap_load_out, 32'h0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_bit("to_err_cleared", access_err, 1'b0);
    next_cycle();

    // No-ops: valid without read/write, then read without valid plus a stray ack.
    valid_in = 1'b1;
    @(negedge clk);
    check_bit("nop1_stall", stall, 1'b0);
    next_cycle();
    valid_in    = 1'b0;
    mem_read_in = 1'b1;
    dmem_ack    = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    check_bit("nop1_req", dmem_req, 1'b0);
    check_bit("nop1_err", access_err, 1'b0);
    check_bit("nop2_stall", stall, 1'b0);
    next_cycle();
    @(negedge clk);
    check_bit("nop2_req", dmem_req, 1'b0);
    check_bit("nop2_lv", load_valid, 1'b0);
    check_bit("nop2_err", access_err, 1'b0);
    check("nop2_load", wrap_load_out, 32'h0);
    idle_inputs();
    next_cycle();

    // Reset during BUSY, then a late ack after release.
    run_vec(vecs[0], 100);
    valid_in    = 1'b1;
    mem_read_in = 1'b1;
    funct3_in   = 3'b010;
    addr_in     = 32'h0000_0500;
    next_cycle();
    check_bit("rb_busy_req", dmem_req, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_bit("rb_req", dmem_req, 1'b0);
    check_bit("rb_we", dmem_we, 1'b0);
    check("rb_addr", dmem_addr, 32'h0);
    check("rb_wdata", dmem_wdata, 32'h0);
    check("rb_wstrb", {28'h0, dmem_wstrb}, 32'h0);
    check("rb_load", wrap_load_out, 32'h0);
    check_bit("rb_lv", load_valid, 1'b0);
    check_bit("rb_err", access_err, 1'b0);
    check_bit("rb_stall", stall, 1'b0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_bit("rb_ack_req", dmem_req, 1'b0);
    check_bit("rb_ack_stall", stall, 1'b0);
    next_cycle();
    @(negedge clk);
    check_bit("rb_ack_lv", load_valid, 1'b0);
    check("rb_ack_load", wrap_load_out, 32'h0);
    dmem_ack = 1'b0;
    next_cycle();
    // FSM must be in IDLE: a fresh store launches normally.
    run_vec('{1'b0, 1'b1, 3'b010, 32'h0000_0600, 32'hCAFE_F00D, 1, 32'h0, 1'b0,
              32'h0000_0600, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0}, 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, maximum BUSY cycles to wait for dmem_ack before aborting (range 1-255).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: valid_in  in  1  instruction in MEM stage is valid.
REQ-005 SHALL have ports: mem_read_in, mem_write_in  in  1 each  load / store request.
REQ-006 SHALL have port: funct3_in  in  3  RV32I access size/sign code.
REQ-007 SHALL have port: addr_in  in  32  byte address (ALU result).
REQ-008 SHALL have port: store_data_in  in  32  rs2 store data.
REQ-009 SHALL have ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_wstrb out 4  data-memory request bus, all registered.
REQ-010 SHALL have ports: dmem_ack in 1, dmem_rdata in 32  memory response; rdata valid when ack=1.
REQ-011 SHALL have ports: wrap_load_out out 32 (extended load data), load_valid out 1, stall out 1, access_err out 1.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL define access start = IDLE & valid_in & exactly one of mem_read_in/mem_write_in & legal & aligned.
REQ-014 SHALL treat as legal: loads funct3 000/001/010/100/101; stores 000/001/010; other codes illegal.
REQ-015 SHALL treat as misaligned: halfword with addr_in[0]=1; word with addr_in[1:0]!=0.
REQ-016 SHALL, on access start, go to BUSY next edge with dmem_req=1, dmem_addr={addr_in[31:2],2'b00}, dmem_we=mem_write_in, and latch funct3 and addr_in[1:0].
REQ-017 SHALL drive stores: SB wdata={4{data[7:0]}}, wstrb=0001<<addr[1:0]; SH wdata={2{data[15:0]}}, wstrb=0011<<{addr[1],1'b0}; SW wdata=data, wstrb=1111; loads wstrb=0000.
REQ-018 SHALL hold all dmem_* outputs stable while dmem_req=1.
REQ-019 SHALL, on dmem_ack in BUSY, clear dmem_req and enter DONE on that edge; for loads, register the extended result into wrap_load_out on the same edge.
REQ-020 SHALL extend loads by latched lane: LB/LBU select byte addr[1:0], LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
REQ-021 SHALL pulse load_valid=1 for exactly the DONE cycle of a completed load; 0 otherwise.
REQ-022 SHALL hold wrap_load_out until the next completed or aborted load.
REQ-023 SHALL drive stall combinationally = access start | BUSY; stall=0 in DONE and in the first IDLE cycle after DONE.
REQ-024 SHALL return DONE -> IDLE unconditionally; a request presented in DONE SHALL NOT start an access (same instruction, pipeline advances).
REQ-025 SHALL ignore dmem_ack in IDLE and DONE.
REQ-026 SHALL count BUSY cycles from 1; if count reaches TIMEOUT_CYCLES with no ack, clear dmem_req, go to DONE, set wrap_load_out=0 for loads, and pulse access_err in DONE; load_valid SHALL stay 0.
REQ-027 SHALL, for valid_in with misaligned, illegal, or both read/write set in IDLE, issue no bus request, hold stall=0, and pulse access_err for exactly the next cycle (registered).
REQ-028 SHALL treat valid_in=0 or no read/write as a no-op with no outputs changing.

Reset
REQ-029 SHALL, on rst=0, immediately force state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0, wrap_load_out=0, load_valid=0, access_err=0, timeout counter=0.
REQ-030 SHALL drive stall=0 while in reset.
REQ-031 SHALL discard an in-flight access on reset; a dmem_ack arriving after reset release SHALL be ignored.

Verification
REQ-032 SHALL cover LB addr 0x103, ack after 2 cycles with rdata 0x80FF1234 -> dmem_addr=0x100, stall high 3 cycles, wrap_load_out=0xFFFFFF80, load_valid one pulse.
REQ-033 SHALL cover LHU addr 0x102, rdata 0x80FF1234 -> wrap_load_out=0x000080FF; LH same -> 0xFFFF80FF.
REQ-034 SHALL cover SB addr 0x201, data 0x000000AB, immediate ack -> dmem_addr=0x200, wstrb=0010, wdata=0xABABABAB, dmem_we=1, load_valid=0.
REQ-035 SHALL cover LW addr 0x102 -> no dmem_req, stall=0, access_err one-cycle pulse; same for funct3=011.
REQ-036 SHALL cover TIMEOUT_CYCLES=4, no ack -> dmem_req drops after 4 BUSY cycles, access_err pulse, wrap_load_out=0.
REQ-037 SHALL cover rst=0 in BUSY, then ack after release -> all outputs at reset values, no load_valid, FSM in IDLE.
